alu_result_collector: RTL

//  Downstream stage of the 16-bit ALU top. Each cycle, selects the single active unit output
//  (arith/logic/cmp/shift) by its flag. Tags the result with unit ID and carry, then queues it
//  in a first-word-fall-through FIFO. The FIFO is drained by a valid/ready consumer
//  (register file or bus writer).

---
 rtl/alu_result_collector.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_result_collector.sv
// alu_result_collector
//   Collects the single active ALU unit result each cycle, tags it with the unit
//   ID and carry, and queues it in a first-word-fall-through FIFO drained by a
//   valid/ready consumer. Sticky OVERFLOW / MULTI_ERR flags report drops and
//   conflicting unit flags.
//   Optional build macro: RES_PARITY_EN adds a stored even-parity bit over
//   {unit, carry, data}, presented on RES_PARITY.
module alu_result_collector #(
    parameter int unsigned In_out = 16,
    parameter int unsigned PTR_W  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [In_out-1:0] Arith_OUT,
    input  logic [In_out-1:0] Logic_OUT,
    input  logic [In_out-1:0] CMP_OUT,
    input  logic [In_out-1:0] Shift_OUT,
    input  logic              Carry_OUT,
    input  logic              Arith_Flag,
    input  logic              Logic_Flag,
    input  logic              CMP_Flag,
    input  logic              Shift_Flag,
    input  logic              CLR_ERR,
    input  logic              RES_READY,
    output logic              RES_VALID,
    output logic [In_out-1:0] RES_DATA,
    output logic [1:0]        RES_UNIT,
    output logic              RES_CARRY,
    output logic [PTR_W:0]    FIFO_COUNT,
    output logic              FIFO_FULL,
    output logic              OVERFLOW,
`ifdef RES_PARITY_EN
    output logic              RES_PARITY,
`endif
    output logic              MULTI_ERR
);

    localparam int unsigned    DEPTH    = 1 << PTR_W;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

`ifdef RES_PARITY_EN
    localparam int unsigned ENTRY_W = In_out + 4;
`else
    localparam int unsigned ENTRY_W = In_out + 3;
`endif

    typedef enum logic [1:0] {
        UNIT_ARITH = 2'd0,
        UNIT_LOGIC = 2'd1,
        UNIT_CMP   = 2'd2,
        UNIT_SHIFT = 2'd3
    } unit_e;

    // Control state
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             overflow_q;
    logic             multi_err_q;

    // Storage (not reset; only control state is)
    logic [ENTRY_W-1:0] mem [DEPTH];

    // Request decode
    logic [3:0]        flags;
    logic [2:0]        flag_cnt;
    logic              push_req;
    logic              multi_hit;
    unit_e             sel_unit;
    logic [In_out-1:0] sel_data;
    logic              sel_carry;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Handshake
    logic empty;
    logic full;
    logic pop_ok;
    logic push_ok;
    logic overflow_set;

    // Count active flags and pick the unit whose result gets queued
    always_comb begin
        flags     = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
        flag_cnt  = {2'b00, Arith_Flag} + {2'b00, Logic_Flag}
                  + {2'b00, CMP_Flag} + {2'b00, Shift_Flag};
        push_req  = (flag_cnt == 3'd1);
        multi_hit = (flag_cnt >= 3'd2);
        sel_unit  = UNIT_ARITH;
        sel_data  = '0;
        sel_carry = 1'b0;
        case (flags)
            4'b0001: begin
                sel_unit  = UNIT_ARITH;
                sel_data  = Arith_OUT;
                sel_carry = Carry_OUT;
            end
            4'b0010: begin
                sel_unit = UNIT_LOGIC;
                sel_data = Logic_OUT;
            end
            4'b0100: begin
                sel_unit = UNIT_CMP;
                sel_data = CMP_OUT;
            end
            4'b1000: begin
                sel_unit = UNIT_SHIFT;
                sel_data = Shift_OUT;
            end
            default: begin
                sel_unit  = UNIT_ARITH;
                sel_data  = '0;
                sel_carry = 1'b0;
            end
        endcase
    end

    // Pack the tagged entry written into the FIFO
    always_comb begin
`ifdef RES_PARITY_EN
        wr_entry = {^{sel_unit, sel_carry, sel_data}, sel_unit, sel_carry, sel_data};
`else
        wr_entry = {sel_unit, sel_carry, sel_data};
`endif
    end

    // Push/pop qualification; a full FIFO still accepts a push when it also pops
    always_comb begin
        empty        = (count == '0);
        full         = (count == FULL_CNT);
        pop_ok       = !empty && RES_READY;
        push_ok      = push_req && (!full || pop_ok);
        overflow_set = push_req && full && !pop_ok;
    end

    // Pointer and occupancy tracking; count kept separately so full/empty never alias
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Sticky error flags; a set in the same cycle as CLR_ERR wins
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow_q  <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (CLR_ERR) begin
                overflow_q <= 1'b0;
            end
            if (multi_hit) begin
                multi_err_q <= 1'b1;
            end else if (CLR_ERR) begin
                multi_err_q <= 1'b0;
            end
        end
    end

    // FWFT head presentation, forced to zero while empty
    always_comb begin
        rd_entry   = mem[rd_ptr];
        RES_VALID  = !empty;
        FIFO_COUNT = count;
        FIFO_FULL  = full;
        OVERFLOW   = overflow_q;
        MULTI_ERR  = multi_err_q;
        RES_DATA   = '0;
        RES_UNIT   = '0;
        RES_CARRY  = 1'b0;
`ifdef RES_PARITY_EN
        RES_PARITY = 1'b0;
`endif
        if (!empty) begin
            RES_DATA  = rd_entry[In_out-1:0];
            RES_CARRY = rd_entry[In_out];
            RES_UNIT  = rd_entry[In_out+2:In_out+1];
`ifdef RES_PARITY_EN
            RES_PARITY = rd_entry[In_out+3];
`endif
        end
    end

endmodule
